// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_if
//  Description : Bundle of all non-clock/reset signals of instr_encoder.
//                The request side (start, in_*) is driven by the master; the
//                instruction-memory write port and status outputs are driven
//                by the slave, which is the encoder itself.
//  Signals     : start       begin a new program image at word address 0
//                in_valid    encode request present
//                in_ready    request accepted when in_valid & in_ready
//                in_op       opcode selector (0..9 legal, 10..15 illegal)
//                in_rs/rt/rd register fields
//                in_imm      16-bit immediate
//                in_target   word address for BEQ / J
//                in_last     final instruction of the image
//                imem_we     instruction-memory write strobe
//                imem_addr   write word address
//                imem_wdata  encoded instruction word
//                busy        encoder in RUN or SEAL
//                done        image complete
//                error       sticky fault flag
//                count       words written in the current image
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_encoder_if;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [7:0]  in_target;
    logic        in_last;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  count;

    // Request source (e.g. a program loader or a testbench).
    modport master (
        output start, in_valid, in_op, in_rs, in_rt, in_rd,
               in_imm, in_target, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata,
               busy, done, error, count
    );

    // The encoder.
    modport slave (
        input  start, in_valid, in_op, in_rs, in_rt, in_rd,
               in_imm, in_target, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata,
               busy, done, error, count
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Streams encode requests into 32-bit MIPS-style instruction
//                words and writes them to consecutive word addresses of an
//                instruction memory, one word per cycle.  Each image is
//                terminated by a jump-to-self "seal" word.  Illegal opcodes
//                write a zero word and raise the sticky error flag; running
//                out of address space forces an early seal at address 255.
//  Ports       : clk    rising-edge system clock
//                reset  synchronous active-high reset
//                bus    instr_encoder_if.slave (request handshake, memory
//                       write port and status outputs)
//  Revision    : 1.0  initial release
// ============================================================================
module instr_encoder (
    input wire       clk,
    input wire       reset,
    instr_encoder_if.slave bus
);

    // ------------------------------------------------------------------------
    // Opcode selector values on in_op
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_OP_ADDU  = 4'd0;
    localparam logic [3:0] c_OP_SUBU  = 4'd1;
    localparam logic [3:0] c_OP_AND   = 4'd2;
    localparam logic [3:0] c_OP_OR    = 4'd3;
    localparam logic [3:0] c_OP_SLTU  = 4'd4;
    localparam logic [3:0] c_OP_LW    = 4'd5;
    localparam logic [3:0] c_OP_SW    = 4'd6;
    localparam logic [3:0] c_OP_BEQ   = 4'd7;
    localparam logic [3:0] c_OP_ADDIU = 4'd8;
    localparam logic [3:0] c_OP_J     = 4'd9;

    // ------------------------------------------------------------------------
    // Instruction field encodings
    // ------------------------------------------------------------------------
    localparam logic [5:0] c_MOP_RTYPE = 6'b000000;
    localparam logic [5:0] c_MOP_LW    = 6'b100011;
    localparam logic [5:0] c_MOP_SW    = 6'b101011;
    localparam logic [5:0] c_MOP_ADDIU = 6'b001001;
    localparam logic [5:0] c_MOP_BEQ   = 6'b000100;
    localparam logic [5:0] c_MOP_J     = 6'b000010;

    localparam logic [5:0] c_FN_ADDU   = 6'b100001;
    localparam logic [5:0] c_FN_SUBU   = 6'b100011;
    localparam logic [5:0] c_FN_AND    = 6'b100100;
    localparam logic [5:0] c_FN_OR     = 6'b100101;
    localparam logic [5:0] c_FN_SLTU   = 6'b101011;

    // Highest writable word address; reaching it without in_last forces
    // the seal word to occupy it.
    localparam logic [8:0] c_PC_LIMIT  = 9'd255;

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SEAL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [8:0]  r_pc;        // next write address
    logic [8:0]  r_count;     // words written in this image (up to 256)
    logic        r_we;
    logic [7:0]  r_addr;
    logic [31:0] r_wdata;
    logic        r_busy;
    logic        r_done;
    logic        r_error;

    logic        w_ready;
    logic        w_accept;
    logic [9:0]  w_off10;     // BEQ word offset, 10-bit two's complement
    logic [31:0] w_word;
    logic        w_illegal;

    // Requests are only taken while running with address space left.  The
    // cycle in which start is sampled is always IDLE or DONE, so a request
    // can never be accepted together with start.
    assign w_ready  = (r_state == S_RUN) && (r_pc < c_PC_LIMIT);
    assign w_accept = w_ready && bus.in_valid;

    // Branch offset is relative to the word after the branch.  With target
    // and pc both in 0..255 the result lies in -256..255, which 10 bits hold.
    assign w_off10  = {2'b00, bus.in_target} - {1'b0, r_pc} - 10'd1;

    // ------------------------------------------------------------------------
    // Instruction encoder
    // ------------------------------------------------------------------------
    always_comb begin
        w_word    = 32'h0000_0000;
        w_illegal = 1'b0;
        case (bus.in_op)
            c_OP_ADDU:  w_word = {c_MOP_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd,
                                  5'b00000, c_FN_ADDU};
            c_OP_SUBU:  w_word = {c_MOP_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd,
                                  5'b00000, c_FN_SUBU};
            c_OP_AND:   w_word = {c_MOP_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd,
                                  5'b00000, c_FN_AND};
            c_OP_OR:    w_word = {c_MOP_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd,
                                  5'b00000, c_FN_OR};
            c_OP_SLTU:  w_word = {c_MOP_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd,
                                  5'b00000, c_FN_SLTU};
            c_OP_LW:    w_word = {c_MOP_LW,    bus.in_rs, bus.in_rt, bus.in_imm};
            c_OP_SW:    w_word = {c_MOP_SW,    bus.in_rs, bus.in_rt, bus.in_imm};
            c_OP_ADDIU: w_word = {c_MOP_ADDIU, bus.in_rs, bus.in_rt, bus.in_imm};
            c_OP_BEQ:   w_word = {c_MOP_BEQ,   bus.in_rs, bus.in_rt,
                                  {6{w_off10[9]}}, w_off10};
            c_OP_J:     w_word = {c_MOP_J, 18'b0, bus.in_target};
            default: begin
                // Illegal opcodes still occupy a word so that addresses of
                // later instructions are unaffected.
                w_word    = 32'h0000_0000;
                w_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequencer and registered memory-write port
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // Dropping r_we here also discards any write registered on the
            // previous edge.
            r_state <= S_IDLE;
            r_pc    <= 9'd0;
            r_count <= 9'd0;
            r_we    <= 1'b0;
            r_addr  <= 8'd0;
            r_wdata <= 32'h0000_0000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            // Strobe is a single-cycle pulse; address/data hold otherwise.
            r_we <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_pc    <= 9'd0;
                        r_count <= 9'd0;
                        r_error <= 1'b0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end

                S_RUN: begin
                    if (w_accept) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_pc[7:0];
                        r_wdata <= w_word;
                        r_pc    <= r_pc + 9'd1;
                        r_count <= r_count + 9'd1;
                        if (w_illegal) begin
                            r_error <= 1'b1;
                        end
                        if (bus.in_last) begin
                            r_state <= S_SEAL;
                        end
                    end else if (r_pc == c_PC_LIMIT) begin
                        // Out of space before in_last: seal at the top word.
                        r_error <= 1'b1;
                        r_state <= S_SEAL;
                    end
                end

                S_SEAL: begin
                    // Jump-to-self so a runaway fetch parks at the image end.
                    r_we    <= 1'b1;
                    r_addr  <= r_pc[7:0];
                    r_wdata <= {c_MOP_J, 18'b0, r_pc[7:0]};
                    r_count <= r_count + 9'd1;
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.in_ready   = w_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
    assign bus.count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Scoreboard bench for instr_encoder.  The stimulus process
//                pushes the expected (address, word) of every write it causes
//                into a queue; an independent monitor pops and compares each
//                write the encoder presents, including a back-to-back timing
//                flag.  Status outputs are checked directly at known cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_encoder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_encoder_if bus ();

    instr_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        b2b;   // write must follow the previous one by 1 cycle
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_wr = -10;
    int   n_wr    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: one comparison per presented write
    // ------------------------------------------------------------------------
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.imem_we === 1'b1) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL write%0d: unexpected write addr=0x%02h data=0x%08h",
                         n_wr, bus.imem_addr, bus.imem_wdata);
            end else begin
                e = q.pop_front();
                if (bus.imem_addr !== e.addr || bus.imem_wdata !== e.data ||
                    (e.b2b && cyc != last_wr + 1)) begin
                    n_fail++;
                    $display("FAIL write%0d: got addr=0x%02h data=0x%08h gap=%0d, expected addr=0x%02h data=0x%08h b2b=%0b",
                             n_wr, bus.imem_addr, bus.imem_wdata, cyc - last_wr,
                             e.addr, e.data, e.b2b);
                end
            end
            last_wr = cyc;
            n_wr++;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (always entered and left at posedge + 1)
    // ------------------------------------------------------------------------
    task automatic push(input logic [7:0] a, input logic [31:0] d,
                        input logic b);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.b2b  = b;
        q.push_back(e);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [15:0] imm, input logic [7:0] tgt,
                        input logic last, input logic [7:0] ea,
                        input logic [31:0] ed, input logic b2b);
        bit acc;
        acc = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_rs     = rs;
        bus.in_rt     = rt;
        bus.in_rd     = rd;
        bus.in_imm    = imm;
        bus.in_target = tgt;
        bus.in_last   = last;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) push(ea, ed, b2b);
            @(posedge clk); #1;
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=0 for 20 cycles, expected 1 (addr 0x%02h)", ea);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 4'd0;
        bus.in_rs     = 5'd0;
        bus.in_rt     = 5'd0;
        bus.in_rd     = 5'd0;
        bus.in_imm    = 16'd0;
        bus.in_target = 8'd0;
        bus.in_last   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we",    bus.imem_we,    0);
        chk("rst_addr",  bus.imem_addr,  0);
        chk("rst_wdata", bus.imem_wdata, 0);
        chk("rst_ready", bus.in_ready,   0);
        chk("rst_busy",  bus.busy,       0);
        chk("rst_done",  bus.done,       0);
        chk("rst_error", bus.error,      0);
        chk("rst_count", bus.count,      0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_ready", bus.in_ready, 0);

        // A: single ADDU with last, sealed on the next cycle
        pulse_start();
        chk("a_busy", bus.busy, 1);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 8'h0, 1'b1, 8'd0, 32'h0022_1821, 1'b0);
        idle();
        push(8'd1, 32'h0800_0001, 1'b1);
        @(posedge clk); #1;
        chk("a_done",  bus.done,  1);
        chk("a_busy0", bus.busy,  0);
        chk("a_count", bus.count, 2);
        chk("a_error", bus.error, 0);
        chk("a_ready", bus.in_ready, 0);

        // B: every legal opcode back-to-back, including both BEQ directions
        pulse_start();
        chk("b_done0", bus.done,  0);
        chk("b_count0", bus.count, 0);
        send(4'd5, 5'd29, 5'd8,  5'd0,  16'h0004, 8'h00, 1'b0, 8'd0, 32'h8FA8_0004, 1'b0);
        send(4'd6, 5'd29, 5'd8,  5'd0,  16'h0004, 8'h00, 1'b0, 8'd1, 32'hAFA8_0004, 1'b1);
        send(4'd7, 5'd0,  5'd0,  5'd0,  16'h0000, 8'h00, 1'b0, 8'd2, 32'h1000_FFFD, 1'b1);
        send(4'd9, 5'd0,  5'd0,  5'd0,  16'h0000, 8'h40, 1'b0, 8'd3, 32'h0800_0040, 1'b1);
        send(4'd1, 5'd5,  5'd6,  5'd7,  16'h0000, 8'h00, 1'b0, 8'd4, 32'h00A6_3823, 1'b1);
        send(4'd2, 5'd1,  5'd2,  5'd3,  16'h0000, 8'h00, 1'b0, 8'd5, 32'h0022_1824, 1'b1);
        send(4'd3, 5'd31, 5'd31, 5'd31, 16'h0000, 8'h00, 1'b0, 8'd6, 32'h03FF_F825, 1'b1);
        send(4'd4, 5'd1,  5'd2,  5'd3,  16'h0000, 8'h00, 1'b0, 8'd7, 32'h0022_182B, 1'b1);
        send(4'd8, 5'd4,  5'd5,  5'd9,  16'hFFFF, 8'h00, 1'b0, 8'd8, 32'h2485_FFFF, 1'b1);
        send(4'd7, 5'd1,  5'd2,  5'd0,  16'h0000, 8'd20, 1'b1, 8'd9, 32'h1022_000A, 1'b1);
        idle();
        push(8'd10, 32'h0800_000A, 1'b1);
        @(posedge clk); #1;
        chk("b_done",  bus.done,  1);
        chk("b_count", bus.count, 11);
        chk("b_error", bus.error, 0);

        // C: illegal opcode writes zero, sets error, encoding continues
        pulse_start();
        send(4'd12, 5'd1, 5'd2, 5'd3, 16'h1234, 8'h00, 1'b0, 8'd0, 32'h0000_0000, 1'b0);
        send(4'd0,  5'd1, 5'd2, 5'd3, 16'h0000, 8'h00, 1'b1, 8'd1, 32'h0022_1821, 1'b1);
        idle();
        chk("c_error", bus.error, 1);
        chk("c_busy",  bus.busy,  1);
        push(8'd2, 32'h0800_0002, 1'b1);
        @(posedge clk); #1;
        chk("c_done",  bus.done,  1);
        chk("c_count", bus.count, 3);
        chk("c_error_sticky", bus.error, 1);

        // D: address-space exhaustion forces seal at 255
        pulse_start();
        chk("d_error_clr", bus.error, 0);
        for (int i = 0; i < 255; i++) begin
            send(4'd8, 5'd0, 5'd1, 5'd0, 16'(i), 8'h00, 1'b0,
                 8'(i), 32'h2401_0000 | 32'(i), (i != 0));
        end
        // Request 256 stays presented but must stall.
        @(negedge clk);
        chk("d_stall_ready", bus.in_ready, 0);
        push(8'hFF, 32'h0800_00FF, 1'b0);
        @(posedge clk); #1;
        chk("d_error", bus.error, 1);
        chk("d_busy",  bus.busy,  1);
        @(posedge clk); #1;
        chk("d_done",  bus.done,  1);
        chk("d_count", bus.count, 256);
        chk("d_ready", bus.in_ready, 0);
        idle();

        // E: reset mid-RUN with the next request still presented
        pulse_start();
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 8'h0, 1'b0, 8'd0, 32'h0022_1821, 1'b0);
        send(4'd0, 5'd2, 5'd3, 5'd4, 16'h0, 8'h0, 1'b0, 8'd1, 32'h0043_2021, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("e_we",    bus.imem_we,  0);
        chk("e_count", bus.count,    0);
        chk("e_busy",  bus.busy,     0);
        chk("e_error", bus.error,    0);
        chk("e_addr",  bus.imem_addr, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("e_no_accept", bus.in_ready, 0);
            @(posedge clk); #1;
        end
        idle();
        @(posedge clk); #1;

        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and reset.
REQ-002 clk  in  1  system clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 start  in  1  begin a new program image at word address 0.
REQ-005 in_valid  in  1  encode request present; in_ready  out  1  request accepted when in_valid&in_ready.
REQ-006 in_op  in  4  0=ADDU 1=SUBU 2=AND 3=OR 4=SLTU 5=LW 6=SW 7=BEQ 8=ADDIU 9=J; 10-15 illegal.
REQ-007 in_rs, in_rt, in_rd  in  5 each  register fields; in_imm  in  16  immediate; in_target  in  8  word address for BEQ/J.
REQ-008 in_last  in  1  final instruction of the image.
REQ-009 imem_we  out  1  instruction-memory write strobe; imem_addr  out  8  word address; imem_wdata  out  32  encoded word.
REQ-010 busy  out  1  RUN or SEAL; done  out  1  image complete; error  out  1  sticky fault; count  out  9  words written in the current image.

Function
REQ-011 States SHALL be IDLE, RUN, SEAL and DONE; pc (9 bits) SHALL hold the next write address.
REQ-012 IDLE or DONE with start=1 -> RUN next cycle; pc, count and error cleared; done cleared; start in RUN/SEAL ignored.
REQ-013 in_ready SHALL be 1 only in RUN with pc<255; a request is never accepted in the cycle start is sampled.
REQ-014 Accepted request SHALL produce exactly one write one cycle later: imem_we=1, imem_addr=pc, imem_wdata=encoded word; pc and count then increment.
REQ-015 R-type (ops 0-4): op 000000, [25:21]=rs, [20:16]=rt, [15:11]=rd, [10:6]=0, funct 100001/100011/100100/100101/101011 respectively.
REQ-016 I-type: LW op 100011, SW 101011, ADDIU 001001, [25:21]=rs, [20:16]=rt, [15:0]=in_imm; in_rd ignored.
REQ-017 BEQ: op 000100, rs, rt, [15:0] = sign-extended (in_target - (pc+1)), computed in at least 10-bit two's complement using pc of that word.
REQ-018 J: op 000010, [25:8]=0, [7:0]=in_target.
REQ-019 Illegal in_op SHALL write 0x00000000 at pc, set error, and continue RUN.
REQ-020 Accepted in_last=1 -> SEAL after that word's write; SEAL writes J-to-self (0x08000000 | pc) at pc, increments count, then -> DONE.
REQ-021 In RUN with pc=255, no request is accepted; error SHALL set and state -> SEAL, writing 0x080000FF at address 255.
REQ-022 imem_we SHALL be 0 in every cycle with no write; imem_addr/imem_wdata hold last written values when imem_we=0.
REQ-023 done SHALL be 1 throughout DONE; busy SHALL be 1 throughout RUN and SEAL; error is sticky until start or reset.
REQ-024 Consecutive accepted requests SHALL write on consecutive cycles (throughput 1 word/cycle, no bubbles).

Reset
REQ-025 reset=1 SHALL, in the same edge, force IDLE, pc=0, count=0, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0.
REQ-026 Reset asserted mid-RUN or mid-SEAL SHALL abort with no further write; a pending registered write is discarded.

Verification
REQ-027 start; ADDU rs=1 rt=2 rd=3 last=1 -> addr 0 = 0x00221821, next cycle addr 1 = 0x08000001, then done=1, count=2.
REQ-028 LW rs=29 rt=8 imm=4 at pc 0 -> 0x8FA80004; SW same fields -> 0xAFA80004.
REQ-029 BEQ rs=0 rt=0 target=0 accepted at pc=2 -> addr 2 = 0x1000FFFD; J target=0x40 -> 0x08000040.
REQ-030 in_op=12 at pc 0 -> addr 0 = 0x00000000, error=1, following requests still encoded at addr 1, 2, ...
REQ-031 255 back-to-back non-last ADDIU -> addrs 0-254 written, request 256 stalled (in_ready=0), addr 255 = 0x080000FF, error=1, done=1.
REQ-032 reset after two writes with in_valid held high -> imem_we=0 next cycle, count=0, IDLE, no acceptance until start.
